// File: rtl/barrel_pkg.sv
// Shared constants and helpers for the power-of-two multiply unit.
package barrel_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_SHIFT_W = 2;

    // Largest exponent a SHIFT_W-bit shift_n can encode.
    function automatic int max_shift(input int shift_w);
        return (1 << shift_w) - 1;
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One barrel level: optional left shift by DIST with zero fill.
// Also reports whether any shifted-out bit disagrees with the operand sign.
module barrel_stage #(
    parameter int WIDTH = 4,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted,
    output logic             ovf
);

    generate
        if (DIST >= WIDTH) begin : g_flush
            // Every bit leaves the word, so all of them must match the sign.
            assign shifted = enable ? '0 : data;
            assign ovf     = enable && (data != {WIDTH{sign}});
        end else begin : g_shift
            assign shifted = enable ? {data[WIDTH-1-DIST:0], {DIST{1'b0}}} : data;
            assign ovf     = enable && (data[WIDTH-1 -: DIST] != {DIST{sign}});
        end
    endgenerate

endmodule

// File: rtl/barrel_multiplication.sv
// Registered y = x * 2^shift_n via a log barrel shifter, with signed overflow.
module barrel_multiplication
    import barrel_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   x,
    input  logic [SHIFT_W-1:0] shift_n,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   y,
    output logic               overflow,
    output logic               out_valid
);

    logic [SHIFT_W:0][WIDTH-1:0] stage_data;
    logic [SHIFT_W-1:0]          stage_ovf;
    logic                        sign;
    logic                        ovf_comb;

    assign sign          = x[WIDTH-1];
    assign stage_data[0] = x;

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_stage (
            .data    (stage_data[k]),
            .enable  (shift_n[k]),
            .sign    (sign),
            .shifted (stage_data[k+1]),
            .ovf     (stage_ovf[k])
        );
    end

    // Lost bits must all equal the sign, and the surviving MSB must too.
    assign ovf_comb = (|stage_ovf) | (stage_data[SHIFT_W][WIDTH-1] != sign);

    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y        <= stage_data[SHIFT_W];
                overflow <= ovf_comb;
            end
        end
    end

endmodule

// File: tb/tb_barrel_multiplication.sv
// Bench for barrel_multiplication: directed table, reset/stream sequences,
// and randomized traffic against an arithmetic reference model.
module tb_barrel_multiplication;
    import barrel_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] x;
    logic [1:0] shift_n;
    logic [2:0] shift_w;
    logic       in_valid;
    logic [3:0] y, y_w;
    logic       overflow, overflow_w;
    logic       out_valid, out_valid_w;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    barrel_multiplication dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .shift_n   (shift_n),
        .in_valid  (in_valid),
        .y         (y),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    // Wider exponent so shifts >= WIDTH are exercised.
    barrel_multiplication #(.WIDTH(4), .SHIFT_W(3)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .shift_n   (shift_w),
        .in_valid  (in_valid),
        .y         (y_w),
        .overflow  (overflow_w),
        .out_valid (out_valid_w)
    );

    typedef struct {
        logic [3:0] x;
        logic [1:0] n;
        logic [3:0] y;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // True product x*2^n, then truncate and range-check as a 4-bit signed value.
    task automatic ref_model(input logic [3:0] xi, input int n, output logic [3:0] ry, output logic rovf);
        longint p;
        p    = longint'($signed(xi)) * (longint'(1) << n);
        ry   = p[3:0];
        rovf = (p > 7) || (p < -8);
    endtask

    task automatic drive(input logic [3:0] xi, input logic [1:0] ni, input logic v);
        @(negedge clk);
        x        = xi;
        shift_n  = ni;
        shift_w  = {1'b0, ni};
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0] ey, ey_w;
        logic       eo, eo_w;
        logic       v;

        vecs = '{
            '{4'b1111, 2'd0, 4'b1111, 1'b0}, '{4'b1111, 2'd1, 4'b1110, 1'b0},
            '{4'b1111, 2'd2, 4'b1100, 1'b0}, '{4'b1111, 2'd3, 4'b1000, 1'b0},
            '{4'b0111, 2'd0, 4'b0111, 1'b0}, '{4'b0111, 2'd1, 4'b1110, 1'b1},
            '{4'b0111, 2'd2, 4'b1100, 1'b1}, '{4'b0111, 2'd3, 4'b1000, 1'b1},
            '{4'b0001, 2'd0, 4'b0001, 1'b0}, '{4'b0001, 2'd1, 4'b0010, 1'b0},
            '{4'b0001, 2'd2, 4'b0100, 1'b0}, '{4'b0001, 2'd3, 4'b1000, 1'b1},
            '{4'b1000, 2'd0, 4'b1000, 1'b0}, '{4'b1000, 2'd1, 4'b0000, 1'b1},
            '{4'b0000, 2'd3, 4'b0000, 1'b0}
        };

        rst = 1'b1; x = '0; shift_n = '0; shift_w = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", {4'b0, y}, 8'h0);
        check("reset_ovf", {7'b0, overflow}, 8'h0);
        check("reset_valid", {7'b0, out_valid}, 8'h0);
        check("reset_valid_w", {7'b0, out_valid_w}, 8'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].x, vecs[i].n, 1'b1);
            check($sformatf("vec%0d_y", i), {4'b0, y}, {4'b0, vecs[i].y});
            check($sformatf("vec%0d_ovf", i), {7'b0, overflow}, {7'b0, vecs[i].ovf});
            check($sformatf("vec%0d_valid", i), {7'b0, out_valid}, 8'h1);
        end

        // Reset wins over a valid operand in the same cycle.
        drive(4'b0101, 2'd1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_y", {4'b0, y}, 8'h0);
        check("rst_mid_ovf", {7'b0, overflow}, 8'h0);
        check("rst_mid_valid", {7'b0, out_valid}, 8'h0);
        @(negedge clk);
        rst = 1'b0;
        x = 4'b0011; shift_n = 2'd1; shift_w = 3'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_y", {4'b0, y}, 8'h06);
        check("rst_rel_valid", {7'b0, out_valid}, 8'h1);

        // Back-to-back, then a bubble that must hold y.
        drive(4'b0010, 2'd2, 1'b1);
        check("strm0_y", {4'b0, y}, 8'h08);
        check("strm0_ovf", {7'b0, overflow}, 8'h1);
        drive(4'b1110, 2'd1, 1'b1);
        check("strm1_y", {4'b0, y}, 8'h0C);
        check("strm1_ovf", {7'b0, overflow}, 8'h0);
        drive(4'b0111, 2'd3, 1'b0);
        check("strm_idle_valid", {7'b0, out_valid}, 8'h0);
        check("strm_idle_y", {4'b0, y}, 8'h0C);
        check("strm_idle_ovf", {7'b0, overflow}, 8'h0);

        // Randomized traffic; expected outputs hold across invalid cycles.
        ey = y; eo = overflow; ey_w = y_w; eo_w = overflow_w;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            x        = 4'($urandom);
            shift_w  = 3'($urandom);
            shift_n  = 2'($urandom);
            v        = ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (v) begin
                ref_model(x, int'(shift_n), ey, eo);
                ref_model(x, int'(shift_w), ey_w, eo_w);
            end
            @(posedge clk);
            #1;
            check("rnd_y", {4'b0, y}, {4'b0, ey});
            check("rnd_ovf", {7'b0, overflow}, {7'b0, eo});
            check("rnd_valid", {7'b0, out_valid}, {7'b0, v});
            check("rnd_w_y", {4'b0, y_w}, {4'b0, ey_w});
            check("rnd_w_ovf", {7'b0, overflow_w}, {7'b0, eo_w});
            check("rnd_w_valid", {7'b0, out_valid_w}, {7'b0, v});
        end

        // Every shift >= WIDTH on the wide instance, incl. x = 0 and x = -1.
        for (int s = 4; s <= max_shift(3); s++) begin
            foreach (vecs[i]) begin
                @(negedge clk);
                x = vecs[i].x; shift_w = 3'(s); in_valid = 1'b1;
                ref_model(x, s, ey_w, eo_w);
                @(posedge clk);
                #1;
                check("big_shift_y", {4'b0, y_w}, 8'h0);
                check("big_shift_ovf", {7'b0, overflow_w}, {7'b0, eo_w});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/barrel_multiplication.md
# barrel_multiplication

Registered two's-complement multiply-by-power-of-two unit: computes y = x · 2^shift_n with a logarithmic barrel shifter and flags signed overflow. It serves as a cheap scaling stage in datapaths where one operand is always a power of two. The result appears one clock after the operand is presented.

## Interface
- WIDTH, default 4: operand and result width in bits (≥ 2).
- SHIFT_W, default 2: shift-amount width; legal shifts are 0 … 2^SHIFT_W − 1. Any value is allowed, including shifts ≥ WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  WIDTH  signed two's-complement operand.
- shift_n  input  SHIFT_W  unsigned exponent n.
- in_valid  input  1  qualifies x and shift_n in this cycle.
- y  output  WIDTH  registered result, x · 2^n truncated to WIDTH bits.
- overflow  output  1  registered; set when the true signed product does not fit in WIDTH bits.
- out_valid  output  1  registered; y and overflow are valid.

## Operation
- Result: y = (x << n) mod 2^WIDTH, an arithmetic left shift with zero fill from the LSB.
- Barrel structure has SHIFT_W stages. Stage k shifts left by 2^k when shift_n[k] = 1 and passes the data through otherwise. Applying the stages in order 0 … SHIFT_W−1 gives a total shift of n.
- If n ≥ WIDTH, y = 0.
- overflow = 1 when either of these holds:
  - any bit shifted out of the MSB differs from x[WIDTH−1], or
  - y[WIDTH−1] ≠ x[WIDTH−1].
  - Equivalent definition: x[WIDTH−1 : WIDTH−1−n] are not all equal. For n ≥ WIDTH, overflow = 1 unless x = 0.
- n = 0: y = x, overflow = 0.
- x = 0: y = 0, overflow = 0 for every n.
- There is no backpressure; a new operand is accepted every cycle.
- When in_valid = 0, out_valid drops to 0 on the next edge, and y and overflow hold their previous values.

## Timing
- Latency is exactly 1 cycle. Inputs sampled at edge t appear on y, overflow and out_valid after edge t.
- Throughput is 1 operation per cycle.
- Reset (rst = 1 at an edge):
  - y = 0, overflow = 0, out_valid = 0.
  - Reset takes priority over in_valid in the same cycle.
  - An operation in flight during reset is discarded.
- The first valid result after reset release is produced from the first in_valid = 1 edge that has rst = 0.
- The combinational path is SHIFT_W 2:1 mux levels plus the overflow reduction. No internal pipelining.

## Structure
- Shared package barrel_pkg holds:
  - the default parameter constants (WIDTH = 4, SHIFT_W = 2);
  - a function max_shift(SHIFT_W) = 2^SHIFT_W − 1.
- One sub-module, barrel_stage, parameterised by WIDTH and DIST:
  - inputs: data, enable, and the sign of x;
  - outputs: shifted data, and a per-stage overflow term (the shifted-out bits are not all equal to the sign).
- The top level:
  - instantiates SHIFT_W barrel_stage instances with DIST = 2^k;
  - ORs the per-stage overflow terms together with the final sign-change check;
  - registers y, overflow and out_valid.

## Test plan
- x = 4'b1111 (−1), in_valid = 1, shift_n = 0, 1, 2, 3 held 50 ns each:
  - y = 1111, 1110, 1100, 1000 (−1, −2, −4, −8), each one cycle after it is applied;
  - overflow = 0 throughout.
- x = 4'b0111 (7), shift_n = 0, 1, 2, 3:
  - y = 0111, 1110, 1100, 1000;
  - overflow = 0, 1, 1, 1.
- x = 4'b0001, shift_n = 0 … 3:
  - y = 0001, 0010, 0100, 1000;
  - overflow = 0, 0, 0, 1 (the shift by 3 flips the sign).
- x = 4'b1000 (−8):
  - shift_n = 0 → y = 1000, overflow = 0;
  - shift_n = 1 → y = 0000, overflow = 1.
- Reset behaviour:
  - assert rst during streaming valid inputs → next cycle y = 0, overflow = 0, out_valid = 0;
  - deassert rst while in_valid = 1 with x = 0011, n = 1 → one cycle later y = 0110, out_valid = 1.
- Streaming:
  - back-to-back operands (0010, n = 2), (1110, n = 1), then in_valid = 0 → y = 1000 (overflow = 1), then y = 1100 (overflow = 0);
  - out_valid falls on the cycle after in_valid falls, and y holds 1100.
